// File: rtl/canny_nms_stream.sv
// canny_nms_stream
//   Streaming Canny non-maximum suppression. Takes a raster-order stream of
//   gradient magnitude plus signed gradients. It builds the 3x3 magnitude
//   window from two line buffers and emits one thinned pixel and its
//   quantised direction for each input pixel.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid / in_ready   input handshake (beat taken when both are high)
//   in_sof                marks pixel (0,0); restarts the frame
//   in_mag, in_gx, in_gy  magnitude (unsigned), gradients (two's complement)
//   low_thresh            kept pixels below this are zeroed (sampled per output)
//   out_valid / out_ready output handshake (single register stage)
//   out_mag, out_dir      suppressed magnitude, direction 0/45/90/135 deg
//   out_sof, out_eol      first pixel of frame, last pixel of a line
`timescale 1ns/1ps
module canny_nms_stream #(
    parameter int MAG_W    = 16,
    parameter int GRAD_W   = 16,
    parameter int IMG_W    = 640,
    parameter int IMG_H    = 480,
    parameter int TIE_MODE = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_sof,
    input  logic [MAG_W-1:0]  in_mag,
    input  logic [GRAD_W-1:0] in_gx,
    input  logic [GRAD_W-1:0] in_gy,
    input  logic [MAG_W-1:0]  low_thresh,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [MAG_W-1:0]  out_mag,
    output logic [1:0]        out_dir,
    output logic              out_sof,
    output logic              out_eol
);

    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam int FW = $clog2(IMG_W + 1);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
    localparam logic [FW-1:0] FL_LAST  = FW'(IMG_W);

    typedef enum logic {RUN, FLUSH} state_t;

    state_t state, state_n;

    // Line buffers: lb1 holds the previous row, lb2 the row before that.
    // glb delays the gradients by one line.
    logic [MAG_W-1:0]    lb1 [IMG_W];
    logic [MAG_W-1:0]    lb2 [IMG_W];
    logic [2*GRAD_W-1:0] glb [IMG_W];

    // Two previous window columns: a = centre column - 1, b = centre column.
    logic [MAG_W-1:0]  a_top, a_mid, a_bot, b_top, b_mid, b_bot;
    logic [GRAD_W-1:0] c_gx, c_gy;   // gradient of the current centre pixel

    logic [RW-1:0] in_row, o_row;
    logic [CW-1:0] in_col, o_col;
    logic [FW-1:0] fl_cnt;

    logic              accept, out_free, emit, load, border, keep, last_in;
    logic [RW-1:0]     eff_row;
    logic [CW-1:0]     eff_col;
    logic [MAG_W-1:0]  rd1, rd2, n1, n2, kept_mag;
    logic [2*GRAD_W-1:0] grd;
    logic [GRAD_W-1:0] ax, ay;
    logic [1:0]        dir;

    function automatic logic [GRAD_W-1:0] abs_sat(input logic [GRAD_W-1:0] v);
        if (!v[GRAD_W-1])
            return v;
        else if (v == {1'b1, {(GRAD_W-1){1'b0}}})
            return {1'b0, {(GRAD_W-1){1'b1}}};   // -min has no positive twin
        else
            return -v;
    endfunction

    // NOTE: in_ready depends on out_ready combinationally but never on
    // in_valid, so no combinational loop can form across the handshakes.
    assign out_free = !out_valid || out_ready;
    assign in_ready = (state == RUN) && out_free;
    assign accept   = in_valid && in_ready;

    // A beat flagged in_sof is treated as pixel (0,0) regardless of counters.
    assign eff_row = in_sof ? '0 : in_row;
    assign eff_col = in_sof ? '0 : in_col;
    assign last_in = (eff_row == ROW_LAST) && (eff_col == COL_LAST);

    assign rd1 = lb1[eff_col];
    assign rd2 = lb2[eff_col];
    assign grd = glb[eff_col];

    // The first IMG_W+1 beats of a frame only fill the window.
    assign emit = !((eff_row == '0) || ((eff_row == RW'(1)) && (eff_col == '0)));
    assign load = (accept && emit) || ((state == FLUSH) && out_free);

    assign border = (o_row == '0) || (o_row == ROW_LAST) ||
                    (o_col == '0) || (o_col == COL_LAST);

    // Direction quantisation and neighbour selection.
    // Window: m0x = a/b/rd2 tops, m1x = mids/rd1, m2x = bottoms/in_mag.
    always_comb begin
        ax  = abs_sat(c_gx);
        ay  = abs_sat(c_gy);
        dir = 2'd0;
        n1  = a_mid;     // m10
        n2  = rd1;       // m12
        if (ay <= (ax >> 1)) begin
            dir = 2'd0;
        end else if (ax <= (ay >> 1)) begin
            dir = 2'd2;
            n1  = b_top;   // m01
            n2  = b_bot;   // m21
        end else if (c_gx[GRAD_W-1] == c_gy[GRAD_W-1]) begin
            dir = 2'd1;
            n1  = rd2;     // m02
            n2  = a_bot;   // m20
        end else begin
            dir = 2'd3;
            n1  = a_top;   // m00
            n2  = in_mag;  // m22
        end
    end

    always_comb begin
        if (TIE_MODE == 0)
            keep = (b_mid >= n1) && (b_mid >= n2);
        else
            keep = (b_mid > n1) && (b_mid >= n2);
        kept_mag = (keep && (b_mid >= low_thresh)) ? b_mid : '0;
    end

    always_comb begin
        state_n = state;
        case (state)
            RUN:   if (accept && last_in) state_n = FLUSH;
            FLUSH: if (load && (fl_cnt == FL_LAST)) state_n = RUN;
            default: state_n = RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= RUN;
        else        state <= state_n;
    end

    // NOTE: line buffers are plain storage with no reset; their contents are
    // only consumed after a full line of fresh data has been written.
    always_ff @(posedge clk) begin
        if (accept) begin
            lb1[eff_col] <= in_mag;
            lb2[eff_col] <= rd1;
            glb[eff_col] <= {in_gx, in_gy};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            {a_top, a_mid, a_bot, b_top, b_mid, b_bot} <= '0;
            c_gx      <= '0;
            c_gy      <= '0;
            in_row    <= '0;
            in_col    <= '0;
            o_row     <= '0;
            o_col     <= '0;
            fl_cnt    <= '0;
            out_valid <= 1'b0;
            out_mag   <= '0;
            out_dir   <= 2'd0;
            out_sof   <= 1'b0;
            out_eol   <= 1'b0;
        end else begin
            if (accept) begin
                {a_top, a_mid, a_bot} <= {b_top, b_mid, b_bot};
                {b_top, b_mid, b_bot} <= {rd2, rd1, in_mag};
                {c_gx, c_gy}          <= grd;
                if (eff_col == COL_LAST) begin
                    in_col <= '0;
                    in_row <= (eff_row == ROW_LAST) ? '0 : eff_row + RW'(1);
                end else begin
                    in_col <= eff_col + CW'(1);
                    in_row <= eff_row;
                end
            end

            // Output position restarts with a new frame; otherwise it walks
            // raster order one step per loaded output.
            if (accept && in_sof) begin
                o_row <= '0;
                o_col <= '0;
            end else if (load) begin
                if (o_col == COL_LAST) begin
                    o_col <= '0;
                    o_row <= (o_row == ROW_LAST) ? '0 : o_row + RW'(1);
                end else begin
                    o_col <= o_col + CW'(1);
                end
            end

            if ((state == FLUSH) && load)
                fl_cnt <= (fl_cnt == FL_LAST) ? '0 : fl_cnt + FW'(1);

            if (load) begin
                out_valid <= 1'b1;
                out_mag   <= ((state == FLUSH) || border) ? '0 : kept_mag;
                out_dir   <= (state == FLUSH) ? 2'd0 : dir;
                out_sof   <= (o_row == '0) && (o_col == '0);
                out_eol   <= (o_col == COL_LAST);
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: doc/canny_nms_stream.md
Name: canny_nms_stream

Overview:
- Streaming, parametrised Canny non-maximum suppression stage.
- Accepts a raster-order stream of per-pixel magnitude and signed gradients (gx, gy) over a valid/ready handshake.
- Builds the 3x3 magnitude window internally with two line buffers, then emits one thinned-magnitude pixel and its quantised direction per input pixel.
- Sits between the Sobel/magnitude stage and hysteresis thresholding; replaces the externally windowed NMS.

Parameters:
- MAG_W, 16, magnitude width (unsigned).
- GRAD_W, 16, gradient width (signed two's complement).
- IMG_W, 640, pixels per line (>=3).
- IMG_H, 480, lines per frame (>=3).
- TIE_MODE, 0: 0 keeps the centre if >= both neighbours; 1 keeps it if > n1 and >= n2 (plateau thinning).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  input beat valid
- in_ready  out  1  input beat accepted when in_valid && in_ready
- in_sof  in  1  marks pixel (0,0); restarts the frame
- in_mag  in  MAG_W  gradient magnitude
- in_gx  in  GRAD_W  horizontal gradient
- in_gy  in  GRAD_W  vertical gradient
- low_thresh  in  MAG_W  kept pixels below this value are zeroed; sampled per output pixel
- out_valid  out  1  output beat valid
- out_ready  in  1  downstream accept
- out_mag  out  MAG_W  suppressed magnitude
- out_dir  out  2  0=0deg, 1=45deg, 2=90deg, 3=135deg
- out_sof  out  1  first output pixel of frame
- out_eol  out  1  last output pixel of a line

Behaviour:
- Reset (async, rst_n=0):
  - out_valid=0, out_mag=0, out_dir=0, out_sof=0, out_eol=0.
  - Row/column counters = 0, FSM = RUN.
  - Line-buffer contents are don't-care.
- Storage:
  - Two IMG_W-deep line buffers hold magnitude.
  - Centre-pixel gx/gy are delayed by IMG_W+1 beats through one line buffer plus a register.
- Window: accepting input pixel (r,c) completes the window centred on (r-1,c-1). m11 = centre, m01 = above, m21 = below, m10 = left, m12 = right.
- Direction quantisation:
  - ax = |gx|, ay = |gy|; the most-negative value saturates to max positive.
  - ay <= ax>>1 -> dir 0, neighbours (m10,m12).
  - Else ax <= ay>>1 -> dir 2, neighbours (m01,m21).
  - Else sign(gx)==sign(gy) -> dir 1, neighbours (m02,m20).
  - Else dir 3, neighbours (m00,m22).
- Keep rule: per TIE_MODE. A kept value < low_thresh outputs 0. Suppressed output = 0. out_dir is always the quantised direction.
- Borders: centre pixels on row 0, row IMG_H-1, col 0 or col IMG_W-1 output out_mag=0 with the computed dir (dir=0 where the gradient is unavailable, i.e. flush pixels).
- Ordering and count:
  - Exactly IMG_W*IMG_H outputs per frame, in raster order.
  - No output for the first IMG_W+1 accepted inputs.
- Latency: out_valid rises the cycle after the accepting edge of the completing input.
- Handshake:
  - Output is a single register stage; in_ready = (state==RUN) && (!out_valid || out_ready).
  - out_* hold stable while out_valid && !out_ready.
  - The in_valid/out_ready relation never gates on combinational loops.
- FSM RUN -> FLUSH:
  - Entered on acceptance of pixel (IMG_H-1, IMG_W-1).
  - FLUSH emits the remaining IMG_W+1 outputs (all zero, border) with in_ready=0, honouring out_ready.
  - Then returns to RUN with counters at (0,0).
- out_sof is set on output (0,0); out_eol on every output with column IMG_W-1.
- in_sof:
  - Accepted beat with in_sof=1 forces input position (0,0).
  - Not-yet-emitted outputs of the old frame are discarded; an already-registered output still completes its handshake.
  - in_sof on the expected (0,0) beat is a no-op.
- Counters wrap at IMG_W/IMG_H only via the rules above; no other wrap.
- Reset mid-frame or mid-FLUSH: immediate return to reset state; the next frame needs in_sof.

Test Plan:
- IMG_W=IMG_H=5, vertical ridge: mag=100 in col 2, 10 elsewhere; gx=50, gy=0 -> interior col-2 outputs 100 dir 0; other interior pixels 0; 25 outputs; sof on first; eol every 5th.
- Diagonal gradient: gx=40, gy=40 centre 90, m02=m20=80 -> 90 dir 1; gx=40, gy=-40 with m00=95 -> 0 dir 3.
- Plateau: centre=n1=n2=70, dir 0 -> TIE_MODE 0 outputs 70, TIE_MODE 1 outputs 0; low_thresh=80 -> 0 in both.
- gx=-32768, gy=0 -> dir 0, no overflow; gx=0, gy=-32768 -> dir 2.
- Random out_ready (50% duty) over 3 frames -> outputs bit-identical to the no-stall run; 25 per frame; in_ready=0 during each 6-beat flush.
- in_sof asserted at pixel 12 of frame, then rst_n pulse mid-flush -> outputs restart at (0,0) with out_sof; after reset out_valid=0 and out_mag=0.
